// File: rtl/branch_pkg.sv
// rtl/branch_pkg.sv - shared types and constants for the branch trace driver
package branch_pkg;

  localparam int BR_PC_W   = 8;
  localparam int BR_TRIP_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  typedef struct packed {
    logic [BR_PC_W-1:0]   pc;
    logic [BR_TRIP_W-1:0] trip;
  } slot_cfg_t;

  localparam logic [15:0] LFSR_SEED     = 16'hACE1;
  // Taps 16,14,13,11 of a right-shifting Fibonacci register land on bits 0,2,3,5
  localparam logic [15:0] LFSR_TAP_MASK = 16'h002D;

  function automatic logic [15:0] lfsr_step(input logic [15:0] l);
    return {^(l & LFSR_TAP_MASK), l[15:1]};
  endfunction

endpackage

// File: rtl/branch_slot_table.sv
// rtl/branch_slot_table.sv - slot cfg register file plus per-slot loop iteration counters
module branch_slot_table
  import branch_pkg::*;
#(
  parameter int NUM_SLOTS = 4,
  localparam int SLOT_W = $clog2(NUM_SLOTS)
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 cfg_we_i,
  input  logic [SLOT_W-1:0]    cfg_slot_i,
  input  logic [BR_PC_W-1:0]   cfg_pc_i,
  input  logic [BR_TRIP_W-1:0] cfg_trip_i,
  input  logic                 restart_i,
  input  logic                 advance_i,
  input  logic                 freeze_i,
  input  logic [SLOT_W-1:0]    slot_i,
  output logic [BR_PC_W-1:0]   pc_o,
  output logic                 taken_o
);

  slot_cfg_t            cfg_q  [NUM_SLOTS];
  logic [BR_TRIP_W-1:0] iter_q [NUM_SLOTS];

  slot_cfg_t            rd_cfg;
  logic [BR_TRIP_W-1:0] rd_k;
  logic [BR_TRIP_W-1:0] k_next;

  // Same-cycle write and restart are forwarded so the first event of a run sees them
  always_comb begin
    rd_cfg = cfg_q[slot_i];
    if (cfg_we_i && (cfg_slot_i == slot_i)) begin
      rd_cfg = '{pc: cfg_pc_i, trip: cfg_trip_i};
    end
    rd_k    = restart_i ? '0 : iter_q[slot_i];
    taken_o = 1'b0;
    k_next  = '0;
    if (rd_cfg.trip == '0) begin
      taken_o = 1'b1;
    end else if (rd_k < (rd_cfg.trip - BR_TRIP_W'(1))) begin
      taken_o = 1'b1;
      k_next  = rd_k + BR_TRIP_W'(1);
    end
  end

  assign pc_o = rd_cfg.pc;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        cfg_q[i]  <= '{pc: BR_PC_W'(i), trip: '0};
        iter_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        if (cfg_we_i && (cfg_slot_i == SLOT_W'(i))) begin
          cfg_q[i] <= '{pc: cfg_pc_i, trip: cfg_trip_i};
        end
        if (restart_i) begin
          iter_q[i] <= '0;
        end
        if (advance_i && !freeze_i && (slot_i == SLOT_W'(i))) begin
          iter_q[i] <= k_next;
        end
      end
    end
  end

endmodule

// File: rtl/branch_trace_driver.sv
// rtl/branch_trace_driver.sv - emits loop-pattern branch events and scores predictor output
// Optional random outcomes when TRACE_LFSR_EN is defined.
module branch_trace_driver
  import branch_pkg::*;
#(
  parameter int NUM_SLOTS = 4,
  parameter int PC_W      = BR_PC_W,
  parameter int TRIP_W    = BR_TRIP_W,
  parameter int CNT_W     = 32,
  localparam int SLOT_W   = $clog2(NUM_SLOTS)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cfg_we,
  input  logic [SLOT_W-1:0] cfg_slot,
  input  logic [PC_W-1:0]   cfg_pc,
  input  logic [TRIP_W-1:0] cfg_trip,
  input  logic              lfsr_mode,
  input  logic              start,
  input  logic [15:0]       num_events,
  input  logic              pred_taken,
  output logic              out_valid,
  output logic [PC_W-1:0]   out_pc,
  output logic              out_taken,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  event_count,
  output logic [CNT_W-1:0]  mismatch_count
);

  state_e              state_q, state_d;
  logic [15:0]         remain_q, remain_d;
  logic [SLOT_W-1:0]   slot_q, slot_d, slot_sel;
  logic [CNT_W-1:0]    ev_q, ev_d, ev_base;
  logic [CNT_W-1:0]    mm_q, mm_d, mm_base;
  logic                out_valid_q, out_taken_q, chk_valid_q, chk_taken_q;
  logic [PC_W-1:0]     out_pc_q;
  logic                busy_q, done_q;
  logic                issue, start_ok, cfg_ok, mismatch_hit;
  logic [PC_W-1:0]     tbl_pc;
  logic                tbl_taken, ev_taken, use_lfsr, lfsr_bit;

  assign start_ok = start && (state_q == ST_IDLE);
  assign cfg_ok   = cfg_we && (state_q == ST_IDLE);

  always_comb begin
    state_d  = state_q;
    remain_d = remain_q;
    issue    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (num_events != 16'd0) begin
            state_d  = ST_RUN;
            issue    = 1'b1;
            remain_d = num_events - 16'd1;
          end else begin
            state_d = ST_DRAIN;
          end
        end
      end
      ST_RUN: begin
        if (remain_q != 16'd0) begin
          issue    = 1'b1;
          remain_d = remain_q - 16'd1;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: state_d = ST_DONE;
      default:  state_d = ST_IDLE;
    endcase
  end

  branch_slot_table #(.NUM_SLOTS(NUM_SLOTS)) u_table (
    .clk        (clk),
    .reset_n    (reset_n),
    .cfg_we_i   (cfg_ok),
    .cfg_slot_i (cfg_slot),
    .cfg_pc_i   (cfg_pc),
    .cfg_trip_i (cfg_trip),
    .restart_i  (start_ok),
    .advance_i  (issue),
    .freeze_i   (use_lfsr),
    .slot_i     (slot_sel),
    .pc_o       (tbl_pc),
    .taken_o    (tbl_taken)
  );

`ifdef TRACE_LFSR_EN
  logic [15:0] lfsr_q;

  assign use_lfsr = lfsr_mode;
  assign lfsr_bit = lfsr_q[0];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lfsr_q <= LFSR_SEED;
    end else if (issue) begin
      lfsr_q <= lfsr_step(lfsr_q);
    end
  end
`else
  logic unused_lfsr_mode;

  assign unused_lfsr_mode = lfsr_mode;
  assign use_lfsr         = 1'b0;
  assign lfsr_bit         = 1'b0;
`endif

  assign ev_taken = use_lfsr ? lfsr_bit : tbl_taken;

  // A start folds the run-scoped clears into the same edge that issues the first event
  assign slot_sel     = start_ok ? '0 : slot_q;
  assign slot_d       = issue ? (slot_sel + SLOT_W'(1)) : slot_sel;
  assign ev_base      = start_ok ? '0 : ev_q;
  assign mm_base      = start_ok ? '0 : mm_q;
  assign mismatch_hit = chk_valid_q && (pred_taken != chk_taken_q);
  assign ev_d         = (issue && !(&ev_base)) ? ev_base + CNT_W'(1) : ev_base;
  assign mm_d         = (mismatch_hit && !(&mm_base)) ? mm_base + CNT_W'(1) : mm_base;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      remain_q    <= '0;
      slot_q      <= '0;
      ev_q        <= '0;
      mm_q        <= '0;
      out_valid_q <= 1'b0;
      out_pc_q    <= '0;
      out_taken_q <= 1'b0;
      chk_valid_q <= 1'b0;
      chk_taken_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      remain_q    <= remain_d;
      slot_q      <= slot_d;
      ev_q        <= ev_d;
      mm_q        <= mm_d;
      out_valid_q <= issue;
      out_pc_q    <= issue ? tbl_pc : '0;
      out_taken_q <= issue && ev_taken;
      chk_valid_q <= out_valid_q;
      chk_taken_q <= out_taken_q;
      busy_q      <= (state_d != ST_IDLE);
      done_q      <= (state_d == ST_DONE);
    end
  end

  assign out_valid      = out_valid_q;
  assign out_pc         = out_pc_q;
  assign out_taken      = out_taken_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign event_count    = ev_q;
  assign mismatch_count = mm_q;

endmodule

// File: tb/tb_branch_trace_driver.sv
// tb/tb_branch_trace_driver.sv - self-checking bench for branch_trace_driver
module tb_branch_trace_driver;

  localparam int NS    = 4;
  localparam int CNT_W = 4;
  localparam int CMAX  = (1 << CNT_W) - 1;
`ifdef TRACE_LFSR_EN
  localparam bit LFSR_BUILD = 1'b1;
`else
  localparam bit LFSR_BUILD = 1'b0;
`endif

  logic             clk, reset_n, cfg_we, lfsr_mode, start, pred_taken;
  logic [1:0]       cfg_slot;
  logic [7:0]       cfg_pc;
  logic [3:0]       cfg_trip;
  logic [15:0]      num_events;
  logic             out_valid, out_taken, busy, done;
  logic [7:0]       out_pc;
  logic [CNT_W-1:0] event_count, mismatch_count;

  branch_trace_driver #(.NUM_SLOTS(NS), .CNT_W(CNT_W)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .cfg_we         (cfg_we),
    .cfg_slot       (cfg_slot),
    .cfg_pc         (cfg_pc),
    .cfg_trip       (cfg_trip),
    .lfsr_mode      (lfsr_mode),
    .start          (start),
    .num_events     (num_events),
    .pred_taken     (pred_taken),
    .out_valid      (out_valid),
    .out_pc         (out_pc),
    .out_taken      (out_taken),
    .busy           (busy),
    .done           (done),
    .event_count    (event_count),
    .mismatch_count (mismatch_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0]  m_pc   [NS];
  logic [3:0]  m_trip [NS];
  logic [15:0] m_lfsr;
  int exp_pc[$], exp_tk[$], got_pc[$], got_tk[$];

  typedef struct {
    bit wr;
    int trip [NS];
    int n;
    int pmode;
    int exp_ev;
    int exp_mm;
  } vec_t;

  vec_t vt [7];

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic vec_t mkvec(bit wr, int t0, int t1, int t2, int t3, int n, int pm, int ev, int mm);
    vec_t v;
    v.wr = wr; v.trip[0] = t0; v.trip[1] = t1; v.trip[2] = t2; v.trip[3] = t3;
    v.n = n; v.pmode = pm; v.exp_ev = ev; v.exp_mm = mm;
    return v;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < NS; i++) begin
      m_pc[i]   = 8'(i);
      m_trip[i] = 4'd0;
    end
    m_lfsr = 16'hACE1;
  endfunction

  // Loop semantics from the rules: taken unless on the last trip iteration; trip 0 never exits
  function automatic void build_expected(input int n, input bit lmode);
    int k [NS];
    int s, t;
    bit tk;
    for (int j = 0; j < NS; j++) k[j] = 0;
    s = 0;
    exp_pc.delete();
    exp_tk.delete();
    for (int i = 0; i < n; i++) begin
      t  = int'(m_trip[s]);
      tk = (t == 0) || (k[s] < t - 1);
      if (LFSR_BUILD && lmode) tk = m_lfsr[0];
      else k[s] = (k[s] + 1) % ((t < 1) ? 1 : t);
      m_lfsr = {m_lfsr[0] ^ m_lfsr[2] ^ m_lfsr[3] ^ m_lfsr[5], m_lfsr[15:1]};
      exp_pc.push_back(int'(m_pc[s]));
      exp_tk.push_back(int'(tk));
      s = (s + 1) % NS;
    end
  endfunction

  task automatic cfg_write(input int s, input int pc, input int trip);
    cfg_we = 1'b1; cfg_slot = 2'(s); cfg_pc = 8'(pc); cfg_trip = 4'(trip);
    @(posedge clk); #1;
    cfg_we = 1'b0;
    m_pc[s] = 8'(pc); m_trip[s] = 4'(trip);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, " out_valid"}, out_valid, 0);
    chk({tag, " out_pc"}, out_pc, 0);
    chk({tag, " out_taken"}, out_taken, 0);
    chk({tag, " busy"}, busy, 0);
    chk({tag, " done"}, done, 0);
    chk({tag, " event_count"}, event_count, 0);
    chk({tag, " mismatch_count"}, mismatch_count, 0);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    model_reset();
    @(posedge clk); #1;
  endtask

  // pmode: 0 = pred tied 0, 1 = perfect predictor, 2 = random
  task automatic run_check(input string tag, input int n, input int pmode, input bit junk, input bit lmode,
                           input bit wcfg, input int ws, input int wpc, input int wtrip,
                           output int ev_o, output int mm_o);
    int  idx = 0, exp_mism = 0, cyc = 0, last_ev = -100, done_cyc = -1, done_cnt = 0;
    bit  prev_v = 1'b0, prev_tk = 1'b0, p;
    ev_o = -1; mm_o = -1;
    got_pc.delete(); got_tk.delete();
    if (wcfg) begin
      cfg_we = 1'b1; cfg_slot = 2'(ws); cfg_pc = 8'(wpc); cfg_trip = 4'(wtrip);
      m_pc[ws] = 8'(wpc); m_trip[ws] = 4'(wtrip);
    end
    build_expected(n, lmode);
    lfsr_mode = lmode; start = 1'b1; num_events = 16'(n);
    @(posedge clk); #1;
    start = 1'b0; cfg_we = 1'b0;
    while (cyc < n + 20 && done_cnt == 0) begin
      if (out_valid) begin
        got_pc.push_back(int'(out_pc));
        got_tk.push_back(int'(out_taken));
        if (idx < n) begin
          chk($sformatf("%s pc[%0d]", tag, idx), out_pc, exp_pc[idx]);
          chk($sformatf("%s taken[%0d]", tag, idx), out_taken, exp_tk[idx]);
        end else begin
          chk({tag, " surplus event"}, idx, n);
        end
        idx++;
        last_ev = cyc;
      end
      if (prev_v) begin
        p = (pmode == 0) ? 1'b0 : (pmode == 1) ? prev_tk : 1'($urandom);
        if (p != prev_tk) exp_mism++;
      end else begin
        p = (pmode == 0) ? 1'b0 : 1'($urandom);
      end
      pred_taken = p;
      prev_v  = out_valid;
      prev_tk = (out_valid && idx <= n) ? 1'(exp_tk[idx-1]) : 1'b0;
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
        ev_o = int'(event_count);
        mm_o = int'(mismatch_count);
        chk({tag, " event_count"}, event_count, (n > CMAX) ? CMAX : n);
        chk({tag, " mismatch_count"}, mismatch_count, (exp_mism > CMAX) ? CMAX : exp_mism);
        chk({tag, " busy in done"}, busy, 1);
        start = 1'b0; cfg_we = 1'b0;
      end else if (junk) begin
        cfg_we = 1'($urandom); cfg_slot = 2'($urandom); cfg_pc = 8'($urandom);
        cfg_trip = 4'($urandom); start = 1'($urandom); num_events = 16'($urandom);
      end
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0; cfg_we = 1'b0;
    chk({tag, " done pulses"}, done_cnt, 1);
    chk({tag, " events seen"}, idx, n);
    chk({tag, " done latency"}, done_cyc - ((n > 0) ? last_ev : -1), 2);
    chk({tag, " idle busy"}, busy, 0);
    chk({tag, " idle done"}, done, 0);
  endtask

  initial begin
    int ev, mm;
    reset_n = 1'b0; cfg_we = 1'b0; cfg_slot = '0; cfg_pc = '0; cfg_trip = '0;
    lfsr_mode = 1'b0; start = 1'b0; num_events = '0; pred_taken = 1'b0;
    model_reset();

    vt[0] = mkvec(0, 0, 0, 0, 0, 4, 0, 4, 4);
    vt[1] = mkvec(1, 1, 1, 1, 1, 6, 0, 6, 0);
    vt[2] = mkvec(1, 0, 0, 0, 0, 0, 0, 0, 0);
    vt[3] = mkvec(1, 0, 0, 0, 0, 20, 0, 15, 15);
    vt[4] = mkvec(1, 3, 2, 1, 0, 12, 1, 12, 0);
    vt[5] = mkvec(1, 2, 2, 2, 2, 8, 0, 8, 4);
    vt[6] = mkvec(1, 0, 0, 0, 0, 1, 1, 1, 0);

    repeat (2) @(posedge clk);
    #1 chk_zero("reset");
    reset_n = 1'b1;
    @(posedge clk); #1;

    cfg_write(2, 8'h99, 5);
    #2 reset_n = 1'b0;
    #1 chk_zero("idle reset");
    @(posedge clk); #1;
    reset_n = 1'b1;
    model_reset();
    @(posedge clk); #1;

    for (int r = 0; r < 7; r++) begin
      if (vt[r].wr) begin
        for (int s = 0; s < NS; s++) cfg_write(s, 16 * r + s, vt[r].trip[s]);
      end
      run_check($sformatf("vec%0d", r), vt[r].n, vt[r].pmode, 1'b0, 1'b0, 1'b0, 0, 0, 0, ev, mm);
      chk($sformatf("vec%0d final events", r), ev, vt[r].exp_ev);
      chk($sformatf("vec%0d final mismatches", r), mm, vt[r].exp_mm);
      if (r == 0) chk("default slot2 pc", got_pc[2], 2);
    end

    for (int s = 0; s < NS; s++) cfg_write(s, 8'h30 + s, 0);
    cfg_write(0, 8'h10, 3);
    run_check("loop3", 12, 1, 1'b1, 1'b0, 1'b0, 0, 0, 0, ev, mm);
    chk("loop3 slot0 iter0", got_tk[0], 1);
    chk("loop3 slot0 iter1", got_tk[4], 1);
    chk("loop3 slot0 iter2", got_tk[8], 0);

    run_check("cfg_with_start", 3, 2, 1'b0, 1'b0, 1'b1, 0, 8'h77, 1, ev, mm);
    chk("cfg_with_start pc", got_pc[0], 8'h77);
    chk("cfg_with_start taken", got_tk[0], 0);

    cfg_write(0, 8'h21, 2);
    start = 1'b1; num_events = 16'd8; lfsr_mode = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    chk("abort third event valid", out_valid, 1);
    chk("abort third event count", event_count, 3);
    #2 reset_n = 1'b0;
    #1 chk_zero("abort");
    repeat (3) begin
      @(posedge clk); #1;
      chk("abort no done", done, 0);
    end
    reset_n = 1'b1;
    model_reset();
    @(posedge clk); #1;
    cfg_write(0, 8'h21, 2);
    run_check("replay", 8, 2, 1'b0, 1'b0, 1'b0, 0, 0, 0, ev, mm);
    chk("replay slot0 pc", got_pc[0], 8'h21);
    chk("replay slot0 k0", got_tk[0], 1);
    chk("replay slot0 k1", got_tk[4], 0);

    do_reset();
    run_check("lfsr1", 1, 1, 1'b0, 1'b1, 1'b0, 0, 0, 0, ev, mm);
    chk("lfsr1 taken", got_tk[0], 1);
    chk("lfsr1 events", ev, 1);

    for (int it = 0; it < 8; it++) begin
      int nw;
      nw = $urandom_range(0, 3);
      for (int w = 0; w < nw; w++) cfg_write($urandom_range(0, 3), $urandom_range(0, 255), $urandom_range(0, 15));
      run_check($sformatf("rand%0d", it), $urandom_range(1, 40), 2, 1'b1, 1'($urandom), 1'b0, 0, 0, 0, ev, mm);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
